// File: rtl/vgafill.sv
// vgafill: rectangle fill engine for the 4-bit greyscale framebuffer.
// Two pixels per byte (even x in [7:4], odd x in [3:0]), row-major, byte
// address = (y*HRES + x)/2. Edge bytes that are only half covered are
// updated by read-modify-write; fully covered bytes are written directly.
module vgafill #(
    parameter int HRES = 640,
    parameter int VRES = 480,
    parameter int AW   = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [9:0]    x0,
    input  logic [9:0]    x1,
    input  logic [9:0]    y0,
    input  logic [9:0]    y1,
    input  logic [3:0]    colour,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] vmem_addr,
    output logic [7:0]    vmem_wdata,
    output logic          vmem_we,
    output logic          vmem_re,
    input  logic [7:0]    vmem_rdata,
    input  logic          vmem_grant
);

    localparam logic [AW-1:0] HALF_ROW = AW'(HRES / 2);

    typedef enum logic [3:0] {
        S_IDLE, S_ROWINIT, S_ROW, S_LRD, S_LWR,
        S_MID, S_RRD, S_RWR, S_NEXT, S_DONE
    } state_t;

    // Registered state and latched job
    state_t        r_state;
    logic [9:0]    r_y;          // current line
    logic [9:0]    r_y1;         // last line
    logic [3:0]    r_colour;
    logic [9:0]    r_bl;         // byte column of x0
    logic [9:0]    r_br;         // byte column of x1
    logic [9:0]    r_mlo;        // first full byte column
    logic [9:0]    r_mend;       // one past last full byte column
    logic          r_lp;         // left partial present (x0 odd)
    logic          r_rp;         // right partial present (x1 even)
    logic [9:0]    r_col;        // byte column of the current access
    logic [AW-1:0] r_rowbase;    // y*HRES/2
    logic [9:0]    r_cnt;        // remaining ROWINIT additions
    logic [7:0]    r_rd;         // captured read data
    logic          r_rd_fresh;   // read data is on vmem_rdata this cycle
    logic          r_err;

    // Next-state values
    state_t        w_state;
    state_t        w_row_end;
    logic [9:0]    w_y;
    logic [9:0]    w_y1;
    logic [3:0]    w_colour;
    logic [9:0]    w_bl;
    logic [9:0]    w_br;
    logic [9:0]    w_mlo;
    logic [9:0]    w_mend;
    logic          w_lp;
    logic          w_rp;
    logic [9:0]    w_col;
    logic [AW-1:0] w_rowbase;
    logic [9:0]    w_cnt;
    logic [7:0]    w_rd;
    logic          w_rd_fresh;
    logic          w_err;
    logic          w_req_re;
    logic          w_req_we;
    logic [7:0]    w_wdata;
    logic          w_valid;
    logic          w_mid_any;

    assign w_valid   = (x0 <= x1) && (y0 <= y1) &&
                       (32'(x1) < 32'(HRES)) && (32'(y1) < 32'(VRES));
    assign w_mid_any = (r_mlo < r_mend);
    assign w_row_end = (r_y == r_y1) ? S_DONE : S_NEXT;

    // Next-state, datapath and memory request generation
    always_comb begin
        w_state    = r_state;
        w_y        = r_y;
        w_y1       = r_y1;
        w_colour   = r_colour;
        w_bl       = r_bl;
        w_br       = r_br;
        w_mlo      = r_mlo;
        w_mend     = r_mend;
        w_lp       = r_lp;
        w_rp       = r_rp;
        w_col      = r_col;
        w_rowbase  = r_rowbase;
        w_cnt      = r_cnt;
        w_rd       = r_rd_fresh ? vmem_rdata : r_rd;
        w_rd_fresh = 1'b0;
        w_err      = 1'b0;
        w_req_re   = 1'b0;
        w_req_we   = 1'b0;
        w_wdata    = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_valid) begin
                        w_bl      = {1'b0, x0[9:1]};
                        w_br      = {1'b0, x1[9:1]};
                        w_mlo     = {1'b0, x0[9:1]} + {9'd0, x0[0]};
                        w_mend    = {1'b0, x1[9:1]} + {9'd0, x1[0]};
                        w_lp      = x0[0];
                        w_rp      = ~x1[0];
                        w_y       = y0;
                        w_y1      = y1;
                        w_colour  = colour;
                        w_rowbase = '0;
                        w_cnt     = y0;
                        w_state   = S_ROWINIT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_ROWINIT: begin
                // rowbase = y0*HRES/2 by repeated addition, one step per cycle
                if (r_cnt != 10'd0) begin
                    w_rowbase = r_rowbase + HALF_ROW;
                end
                if (r_cnt <= 10'd1) begin
                    w_state = S_ROW;
                end else begin
                    w_cnt = r_cnt - 10'd1;
                end
            end
            S_ROW: begin
                if (r_lp) begin
                    w_col   = r_bl;
                    w_state = S_LRD;
                end else if (w_mid_any) begin
                    w_col   = r_mlo;
                    w_state = S_MID;
                end else begin
                    w_col   = r_br;
                    w_state = S_RRD;
                end
            end
            S_LRD: begin
                w_req_re = 1'b1;
                if (vmem_grant) begin
                    w_rd_fresh = 1'b1;
                    w_state    = S_LWR;
                end
            end
            S_LWR: begin
                w_req_we = 1'b1;
                w_wdata  = {w_rd[7:4], r_colour};
                if (vmem_grant) begin
                    if (w_mid_any) begin
                        w_col   = r_mlo;
                        w_state = S_MID;
                    end else if (r_rp) begin
                        w_col   = r_br;
                        w_state = S_RRD;
                    end else begin
                        w_state = w_row_end;
                    end
                end
            end
            S_MID: begin
                w_req_we = 1'b1;
                w_wdata  = {r_colour, r_colour};
                if (vmem_grant) begin
                    if ((r_col + 10'd1) < r_mend) begin
                        w_col = r_col + 10'd1;
                    end else if (r_rp) begin
                        w_col   = r_br;
                        w_state = S_RRD;
                    end else begin
                        w_state = w_row_end;
                    end
                end
            end
            S_RRD: begin
                w_req_re = 1'b1;
                if (vmem_grant) begin
                    w_rd_fresh = 1'b1;
                    w_state    = S_RWR;
                end
            end
            S_RWR: begin
                w_req_we = 1'b1;
                w_wdata  = {r_colour, w_rd[3:0]};
                if (vmem_grant) begin
                    w_state = w_row_end;
                end
            end
            S_NEXT: begin
                w_rowbase = r_rowbase + HALF_ROW;
                w_y       = r_y + 10'd1;
                w_state   = S_ROW;
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any job in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_y        <= '0;
            r_y1       <= '0;
            r_colour   <= '0;
            r_bl       <= '0;
            r_br       <= '0;
            r_mlo      <= '0;
            r_mend     <= '0;
            r_lp       <= 1'b0;
            r_rp       <= 1'b0;
            r_col      <= '0;
            r_rowbase  <= '0;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_rd_fresh <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_y        <= w_y;
            r_y1       <= w_y1;
            r_colour   <= w_colour;
            r_bl       <= w_bl;
            r_br       <= w_br;
            r_mlo      <= w_mlo;
            r_mend     <= w_mend;
            r_lp       <= w_lp;
            r_rp       <= w_rp;
            r_col      <= w_col;
            r_rowbase  <= w_rowbase;
            r_cnt      <= w_cnt;
            r_rd       <= w_rd;
            r_rd_fresh <= w_rd_fresh;
            r_err      <= w_err;
        end
    end

    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;
    assign vmem_re    = w_req_re;
    assign vmem_we    = w_req_we;
    assign vmem_wdata = w_wdata;
    assign vmem_addr  = (w_req_re | w_req_we) ? (r_rowbase + AW'(r_col)) : '0;

endmodule
